// File: rtl/dmi_adapter_pkg.sv
// -----------------------------------------------------------------------------
// dmi_adapter_pkg
// Shared types and constants for the DMI request adapter:
//   - state_e   : adapter transaction state (IDLE, REQ, RSP)
//   - dmi_req_t : one DMI request {write, addr, wdata}
//   - ADDR_W / DATA_W / REQ_W : field and total request widths
//   - tmo_cnt_width() : width of the timeout counter for a given limit
// -----------------------------------------------------------------------------
package dmi_adapter_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmi_req_t;

    // Counter must hold values up to cycles; never narrower than one bit.
    function automatic int tmo_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmi_req_slot.sv
// -----------------------------------------------------------------------------
// dmi_req_slot
// One-entry holding register for a DMI request. A load in the same cycle as
// an unload replaces the outgoing entry, so the slot stays full with the new
// request. A load into a full slot without an unload is the caller's
// responsibility to avoid (the adapter drops such requests before here).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture load_req this cycle
//   unload    : entry is consumed this cycle
//   load_req  : request to capture
//   valid     : slot holds a request (registered)
//   req       : held request (registered)
// -----------------------------------------------------------------------------
module dmi_req_slot
    import dmi_adapter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     unload,
    input  dmi_req_t load_req,
    output logic     valid,
    output dmi_req_t req
);

    logic     valid_r;
    dmi_req_t req_r;

    // Slot occupancy and contents; load has priority so load+unload refills.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            req_r   <= {REQ_W{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            req_r   <= load_req;
        end else if (unload) begin
            valid_r <= 1'b0;
            req_r   <= req_r;
        end else begin
            valid_r <= valid_r;
            req_r   <= req_r;
        end
    end

    assign valid = valid_r;
    assign req   = req_r;

endmodule

// File: rtl/dmi_req_adapter.sv
// -----------------------------------------------------------------------------
// dmi_req_adapter
// Core-clock stage behind the JTAG DMI synchronizer. Turns single-cycle
// reg_en strobes into a valid/ready request to the debug module, waits for
// the one response each request produces, and returns read data on a stable
// rd_data register. One request arriving while busy is buffered; further
// ones are dropped and flagged. Every transaction is bounded by a timeout.
// Ports:
//   clk, rst            : core clock, synchronous active-high reset
//   reg_en, reg_wr_en   : request strobe, write qualifier
//   reg_wr_addr/_data   : request address / write data
//   rd_data             : registered read data to the JTAG side
//   dm_req_valid/ready  : request handshake to the debug module
//   dm_req_write/addr/wdata : request payload (stable while valid)
//   dm_rsp_valid/rdata  : one-cycle response from the debug module
//   busy                : transaction active or request pending (registered)
//   sticky_ovf          : a request was dropped (pending slot full)
//   sticky_tmo          : a transaction timed out
//   clr_sticky          : clears both sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module dmi_req_adapter
    import dmi_adapter_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_en,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] reg_wr_addr,
    input  logic [DATA_W-1:0] reg_wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic              dm_req_write,
    output logic [ADDR_W-1:0] dm_req_addr,
    output logic [DATA_W-1:0] dm_req_wdata,
    input  logic              dm_rsp_valid,
    input  logic [DATA_W-1:0] dm_rsp_rdata,
    output logic              busy,
    output logic              sticky_ovf,
    output logic              sticky_tmo,
    input  logic              clr_sticky
);

    localparam int             TMO_W      = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic           TMO_EN     = (TIMEOUT_CYCLES > 0);
    // The timeout fires on the edge that ends the last counted cycle, i.e.
    // while the counter still shows TIMEOUT_CYCLES-1.
    localparam int             TMO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_LAST_I[TMO_W-1:0];
    localparam int             TMO_ONE_I  = 1;
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_ONE_I[TMO_W-1:0];

    // Registered state and outputs
    state_e            state_r;
    dmi_req_t          act_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              req_valid_r;
    logic              busy_r;
    logic              ovf_r;
    logic              tmo_flag_r;

    // Per-cycle decisions
    dmi_req_t new_req_s;
    dmi_req_t slot_req_s;
    dmi_req_t dispatch_req_s;
    logic     slot_valid_s;
    logic     slot_valid_nx_s;
    logic     slot_load_s;
    logic     slot_unload_s;
    logic     in_txn_s;
    logic     tmo_hit_s;
    logic     rsp_done_s;
    logic     tmo_done_s;
    logic     complete_s;
    logic     accept_s;
    logic     dispatch_s;
    logic     ovf_evt_s;
    logic     illegal_s;
    state_e   state_nx_s;

    dmi_req_slot u_pending_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (slot_load_s),
        .unload   (slot_unload_s),
        .load_req (new_req_s),
        .valid    (slot_valid_s),
        .req      (slot_req_s)
    );

    // Transaction decisions: dispatch, accept, completion, pending slot, overflow.
    always_comb begin
        new_req_s      = '{write: reg_wr_en, addr: reg_wr_addr, wdata: reg_wr_data};
        in_txn_s       = (state_r == REQ) || (state_r == RSP);
        tmo_hit_s      = TMO_EN && in_txn_s && (tmo_cnt_r == TMO_LAST);
        dispatch_req_s = slot_req_s;
        dispatch_s     = 1'b0;
        slot_load_s    = 1'b0;
        slot_unload_s  = 1'b0;
        rsp_done_s     = 1'b0;
        tmo_done_s     = 1'b0;
        accept_s       = 1'b0;
        ovf_evt_s      = 1'b0;
        illegal_s      = 1'b0;

        case (state_r)
            IDLE: begin
                // A request parked by a completion that had no successor is
                // served first; a simultaneous strobe takes its place.
                if (slot_valid_s) begin
                    dispatch_s    = 1'b1;
                    slot_unload_s = 1'b1;
                    slot_load_s   = reg_en;
                end else if (reg_en) begin
                    dispatch_s     = 1'b1;
                    dispatch_req_s = new_req_s;
                end else begin
                    dispatch_s = 1'b0;
                end
            end
            REQ: begin
                if (tmo_hit_s) begin
                    tmo_done_s = 1'b1;
                end else if (dm_req_ready) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            RSP: begin
                // A real response beats a timeout landing in the same cycle.
                if (dm_rsp_valid) begin
                    rsp_done_s = 1'b1;
                end else if (tmo_hit_s) begin
                    tmo_done_s = 1'b1;
                end else begin
                    rsp_done_s = 1'b0;
                end
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase

        complete_s = rsp_done_s | tmo_done_s;

        if (in_txn_s) begin
            // Completion drains the slot into the active register; a strobe
            // in the same cycle can then refill it without being dropped.
            slot_unload_s  = complete_s & slot_valid_s;
            dispatch_s     = slot_unload_s;
            dispatch_req_s = slot_req_s;
            slot_load_s    = reg_en & (~slot_valid_s | slot_unload_s);
            ovf_evt_s      = reg_en & slot_valid_s & ~slot_unload_s;
        end else begin
            ovf_evt_s = 1'b0;
        end

        if (dispatch_s) begin
            state_nx_s = REQ;
        end else if (complete_s) begin
            state_nx_s = IDLE;
        end else if (accept_s) begin
            state_nx_s = RSP;
        end else if (illegal_s) begin
            state_nx_s = IDLE;
        end else begin
            state_nx_s = state_r;
        end

        slot_valid_nx_s = slot_load_s | (slot_valid_s & ~slot_unload_s);
    end

    // Adapter FSM with its registered outputs, timeout counter and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            act_r       <= {REQ_W{1'b0}};
            tmo_cnt_r   <= {TMO_W{1'b0}};
            rd_data_r   <= {DATA_W{1'b0}};
            req_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            ovf_r       <= 1'b0;
            tmo_flag_r  <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            req_valid_r <= (state_nx_s == REQ);
            busy_r      <= (state_nx_s != IDLE) | slot_valid_nx_s;

            if (dispatch_s) begin
                act_r <= dispatch_req_s;
            end else begin
                act_r <= act_r;
            end

            if (dispatch_s || complete_s) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end else if (in_txn_s) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end

            // Only read completions touch rd_data; writes leave it as is.
            if (rsp_done_s && !act_r.write) begin
                rd_data_r <= dm_rsp_rdata;
            end else if (tmo_done_s && !act_r.write) begin
                rd_data_r <= TIMEOUT_RDATA;
            end else begin
                rd_data_r <= rd_data_r;
            end

            ovf_r      <= ovf_evt_s  | (ovf_r      & ~clr_sticky);
            tmo_flag_r <= tmo_done_s | (tmo_flag_r & ~clr_sticky);
        end
    end

    assign rd_data      = rd_data_r;
    assign dm_req_valid = req_valid_r;
    assign dm_req_write = act_r.write;
    assign dm_req_addr  = act_r.addr;
    assign dm_req_wdata = act_r.wdata;
    assign busy         = busy_r;
    assign sticky_ovf   = ovf_r;
    assign sticky_tmo   = tmo_flag_r;

endmodule

// File: tb/tb_dmi_req_adapter.sv
// -----------------------------------------------------------------------------
// tb_dmi_req_adapter
// Directed bench for dmi_req_adapter. A transaction-level model (active
// request + age + pending queue) predicts every output after each clock edge
// and is compared on each falling edge; directed steps add literal checks.
// -----------------------------------------------------------------------------
module tb_dmi_req_adapter;

    localparam int          T        = 8;
    localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        w;
        logic [6:0]  a;
        logic [31:0] d;
    } mreq_t;

    logic        clk;
    logic        rst;
    logic        reg_en;
    logic        reg_wr_en;
    logic [6:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic [31:0] rd_data;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic        dm_req_write;
    logic [6:0]  dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic        busy;
    logic        sticky_ovf;
    logic        sticky_tmo;
    logic        clr_sticky;

    int checks = 0;
    int errors = 0;

    dmi_req_adapter #(
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_RDATA  (TMO_DATA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_en       (reg_en),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .rd_data      (rd_data),
        .dm_req_valid (dm_req_valid),
        .dm_req_ready (dm_req_ready),
        .dm_req_write (dm_req_write),
        .dm_req_addr  (dm_req_addr),
        .dm_req_wdata (dm_req_wdata),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rsp_rdata (dm_rsp_rdata),
        .busy         (busy),
        .sticky_ovf   (sticky_ovf),
        .sticky_tmo   (sticky_tmo),
        .clr_sticky   (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_have;
    bit          m_acc;
    int          m_age;
    mreq_t       m_act;
    mreq_t       m_pend[$];
    logic [31:0] m_rd;
    bit          m_ovf;
    bit          m_tmo;
    bit          model_ok = 1'b0;

    task automatic m_start(input mreq_t r);
        m_act  = r;
        m_have = 1'b1;
        m_acc  = 1'b0;
        m_age  = 0;
    endtask

    task automatic model_step();
        mreq_t nr;
        mreq_t tmp;
        bit    was_active;
        bit    done;
        bit    tmo_e;
        bit    ovf_e;
        nr    = '{w: reg_wr_en, a: reg_wr_addr, d: reg_wr_data};
        done  = 1'b0;
        tmo_e = 1'b0;
        ovf_e = 1'b0;
        if (rst) begin
            m_have = 1'b0;
            m_acc  = 1'b0;
            m_age  = 0;
            m_act  = '0;
            m_pend.delete();
            m_rd   = 32'h0;
            m_ovf  = 1'b0;
            m_tmo  = 1'b0;
        end else begin
            was_active = m_have;
            if (m_have) begin
                m_age++;
                if (m_acc && dm_rsp_valid) begin
                    done = 1'b1;
                    if (!m_act.w) m_rd = dm_rsp_rdata;
                end else if (m_age >= T) begin
                    done  = 1'b1;
                    tmo_e = 1'b1;
                    if (!m_act.w) m_rd = TMO_DATA;
                end else if (!m_acc && dm_req_ready) begin
                    m_acc = 1'b1;
                end
            end
            if (done) begin
                m_have = 1'b0;
                m_acc  = 1'b0;
            end
            if (!was_active) begin
                if (m_pend.size() > 0) begin
                    tmp = m_pend.pop_front();
                    m_start(tmp);
                    if (reg_en) m_pend.push_back(nr);
                end else if (reg_en) begin
                    m_start(nr);
                end
            end else begin
                if (done && m_pend.size() > 0) begin
                    tmp = m_pend.pop_front();
                    m_start(tmp);
                end
                if (reg_en) begin
                    if (m_pend.size() == 0) m_pend.push_back(nr);
                    else ovf_e = 1'b1;
                end
            end
            if (clr_sticky) begin
                m_ovf = 1'b0;
                m_tmo = 1'b0;
            end
            if (ovf_e) m_ovf = 1'b1;
            if (tmo_e) m_tmo = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            model_ok = 1'b1;
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                check("cyc_rd_data", rd_data, m_rd);
                check("cyc_req_valid", {31'd0, dm_req_valid}, {31'd0, (m_have && !m_acc)});
                check("cyc_req_write", {31'd0, dm_req_write}, {31'd0, m_act.w});
                check("cyc_req_addr", {25'd0, dm_req_addr}, {25'd0, m_act.a});
                check("cyc_req_wdata", dm_req_wdata, m_act.d);
                check("cyc_busy", {31'd0, busy}, {31'd0, (m_have || (m_pend.size() != 0))});
                check("cyc_ovf", {31'd0, sticky_ovf}, {31'd0, m_ovf});
                check("cyc_tmo", {31'd0, sticky_tmo}, {31'd0, m_tmo});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        check(name, {31'd0, got}, {31'd0, want});
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst          = 1'b1;
        reg_en       = 1'b0;
        reg_wr_en    = 1'b0;
        reg_wr_addr  = 7'h00;
        reg_wr_data  = 32'h0;
        dm_req_ready = 1'b0;
        dm_rsp_valid = 1'b0;
        dm_rsp_rdata = 32'h0;
        clr_sticky   = 1'b0;
        cyc();
        cyc();
        check("rst_rd_data", rd_data, 32'h0);
        chk1("rst_valid", dm_req_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ovf", sticky_ovf, 1'b0);
        chk1("rst_tmo", sticky_tmo, 1'b0);
        rst = 1'b0;
        cyc();

        // 1: read, accepted at once, response three cycles after accept
        dm_req_ready = 1'b1;
        reg_en = 1'b1; reg_wr_en = 1'b0; reg_wr_addr = 7'h11; reg_wr_data = 32'h0;
        cyc();
        reg_en = 1'b0;
        chk1("t1_valid", dm_req_valid, 1'b1);
        check("t1_addr", {25'd0, dm_req_addr}, 32'h11);
        chk1("t1_write", dm_req_write, 1'b0);
        cyc();
        chk1("t1_valid_after_accept", dm_req_valid, 1'b0);
        cyc();
        cyc();
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h1234_5678;
        cyc();
        dm_rsp_valid = 1'b0;
        check("t1_rd_data", rd_data, 32'h1234_5678);
        chk1("t1_busy", busy, 1'b0);

        // 2: write held off by ready low for five cycles
        dm_req_ready = 1'b0;
        reg_en = 1'b1; reg_wr_en = 1'b1; reg_wr_addr = 7'h10; reg_wr_data = 32'h8000_0001;
        cyc();
        reg_en = 1'b0; reg_wr_en = 1'b0; reg_wr_addr = 7'h7F; reg_wr_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            chk1("t2_valid_held", dm_req_valid, 1'b1);
            check("t2_addr_held", {25'd0, dm_req_addr}, 32'h10);
            check("t2_wdata_held", dm_req_wdata, 32'h8000_0001);
            chk1("t2_write_held", dm_req_write, 1'b1);
            cyc();
        end
        dm_req_ready = 1'b1;
        cyc();
        dm_req_ready = 1'b0;
        chk1("t2_valid_after_accept", dm_req_valid, 1'b0);
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'hFFFF_0000;
        cyc();
        dm_rsp_valid = 1'b0;
        check("t2_rd_unchanged", rd_data, 32'h1234_5678);
        chk1("t2_busy", busy, 1'b0);

        // 3: three strobes while in RSP: one pends, two drop
        dm_req_ready = 1'b1;
        reg_en = 1'b1; reg_wr_en = 1'b0; reg_wr_addr = 7'h20;
        cyc();
        reg_en = 1'b0;
        cyc();
        reg_en = 1'b1; reg_wr_addr = 7'h21;
        cyc();
        reg_wr_addr = 7'h22;
        cyc();
        reg_wr_addr = 7'h23;
        cyc();
        reg_en = 1'b0;
        chk1("t3_ovf", sticky_ovf, 1'b1);
        chk1("t3_busy", busy, 1'b1);
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'hAAAA_0001;
        cyc();
        dm_rsp_valid = 1'b0;
        chk1("t3_pend_valid", dm_req_valid, 1'b1);
        check("t3_pend_addr", {25'd0, dm_req_addr}, 32'h21);
        check("t3_rd_first", rd_data, 32'hAAAA_0001);
        cyc();
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'hBBBB_0002;
        cyc();
        dm_rsp_valid = 1'b0;
        check("t3_rd_second", rd_data, 32'hBBBB_0002);
        chk1("t3_busy_done", busy, 1'b0);
        clr_sticky = 1'b1;
        cyc();
        clr_sticky = 1'b0;
        chk1("t3_ovf_cleared", sticky_ovf, 1'b0);

        // 4: read never answered times out after eight counted cycles
        reg_en = 1'b1; reg_wr_addr = 7'h30;
        cyc();
        reg_en = 1'b0;
        repeat (7) cyc();
        chk1("t4_tmo_before", sticky_tmo, 1'b0);
        check("t4_rd_before", rd_data, 32'hBBBB_0002);
        chk1("t4_busy_before", busy, 1'b1);
        cyc();
        check("t4_rd_timeout", rd_data, 32'hDEAD_BEEF);
        chk1("t4_tmo_set", sticky_tmo, 1'b1);
        chk1("t4_busy_after", busy, 1'b0);
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h5555_5555;
        cyc();
        dm_rsp_valid = 1'b0;
        check("t4_late_rsp_ignored", rd_data, 32'hDEAD_BEEF);
        clr_sticky = 1'b1;
        cyc();
        clr_sticky = 1'b0;
        chk1("t4_tmo_cleared", sticky_tmo, 1'b0);

        // 5a: response in the very cycle the timeout would fire
        reg_en = 1'b1; reg_wr_addr = 7'h31;
        cyc();
        reg_en = 1'b0;
        repeat (7) cyc();
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h600D_F00D;
        cyc();
        dm_rsp_valid = 1'b0;
        check("t5_rsp_wins", rd_data, 32'h600D_F00D);
        chk1("t5_no_tmo", sticky_tmo, 1'b0);

        // 5b: strobe coinciding with completion while the slot is full
        reg_en = 1'b1; reg_wr_en = 1'b0; reg_wr_addr = 7'h40;
        cyc();
        reg_en = 1'b0;
        cyc();
        reg_en = 1'b1; reg_wr_en = 1'b1; reg_wr_addr = 7'h41; reg_wr_data = 32'h0000_0041;
        cyc();
        reg_wr_en = 1'b0; reg_wr_addr = 7'h42;
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h0000_0040;
        cyc();
        reg_en = 1'b0; dm_rsp_valid = 1'b0;
        chk1("t5_b_valid", dm_req_valid, 1'b1);
        check("t5_b_addr", {25'd0, dm_req_addr}, 32'h41);
        chk1("t5_b_write", dm_req_write, 1'b1);
        chk1("t5_no_ovf", sticky_ovf, 1'b0);
        check("t5_rd_a", rd_data, 32'h0000_0040);
        cyc();
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h0000_0099;
        cyc();
        dm_rsp_valid = 1'b0;
        check("t5_write_rd_kept", rd_data, 32'h0000_0040);
        check("t5_c_addr", {25'd0, dm_req_addr}, 32'h42);
        cyc();
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h0000_0042;
        cyc();
        dm_rsp_valid = 1'b0;
        check("t5_rd_c", rd_data, 32'h0000_0042);
        chk1("t5_busy_done", busy, 1'b0);

        // 6: reset in RSP abandons the transaction, next read works
        reg_en = 1'b1; reg_wr_addr = 7'h50;
        cyc();
        reg_en = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk1("t6_valid", dm_req_valid, 1'b0);
        check("t6_rd_cleared", rd_data, 32'h0);
        chk1("t6_busy", busy, 1'b0);
        check("t6_addr", {25'd0, dm_req_addr}, 32'h0);
        reg_en = 1'b1; reg_wr_addr = 7'h51;
        cyc();
        reg_en = 1'b0;
        cyc();
        dm_rsp_valid = 1'b1; dm_rsp_rdata = 32'h5151_5151;
        cyc();
        dm_rsp_valid = 1'b0;
        check("t6_rd_after", rd_data, 32'h5151_5151);
        chk1("t6_busy_after", busy, 1'b0);

        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
